// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants for the Fetch -> Decode instruction queue.
// Holds the default queue depth, the PC/instruction width defaults and the
// bubble encoding Decode sees when no instruction is available.
package if_id_queue_pkg;

    localparam int          IFQ_DEPTH      = 2;
    localparam int          MEM_ADDR_WIDTH = 32;
    localparam int          REG_DATA_WIDTH = 32;
    localparam logic [31:0] INST_BUBBLE    = 32'b0;

endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: circular instruction queue between Fetch and Decode.
// Buffers up to DEPTH PC/instruction pairs with valid/ready handshakes on
// both sides; flush empties the queue and drops any same-cycle push.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard queue contents and same-cycle push
//   if_valid/if_ready   Fetch handshake (if_ready from registered count only)
//   if_pc, if_inst      entry being pushed
//   id_valid/id_ready   Decode handshake
//   id_pc, id_inst      head entry (0 / bubble when empty)
//   count               number of occupied entries
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = IFQ_DEPTH,
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int INST_W = REG_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [INST_W-1:0] BUBBLE   = INST_W'(INST_BUBBLE);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Full refuses a push even when a pop happens in the same cycle; this
    // keeps if_ready free of any combinational path from id_ready.
    assign if_ready = (count != FULL_CNT);
    assign id_valid = (count != '0);
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready && !flush;

    assign id_pc   = id_valid ? mem[rd_ptr].pc   : '0;
    assign id_inst = id_valid ? mem[rd_ptr].inst : BUBBLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible unless count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DEPTH = 2 instance
    logic        flush2 = 0, v2 = 0, rdy2 = 0;
    logic [31:0] pc2 = 0, in2 = 0;
    logic        ifr2, idv2;
    logic [31:0] idpc2, idin2;
    logic [1:0]  cnt2;

    // DEPTH = 3 instance
    logic        flush3 = 0, v3 = 0, rdy3 = 0;
    logic [31:0] pc3 = 0, in3 = 0;
    logic        ifr3, idv3;
    logic [31:0] idpc3, idin3;
    logic [1:0]  cnt3;

    if_id_queue #(.DEPTH(2), .ADDR_W(32), .INST_W(32)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .if_valid(v2), .if_ready(ifr2),
        .if_pc(pc2), .if_inst(in2), .id_valid(idv2), .id_ready(rdy2),
        .id_pc(idpc2), .id_inst(idin2), .count(cnt2)
    );

    if_id_queue #(.DEPTH(3), .ADDR_W(32), .INST_W(32)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .if_valid(v3), .if_ready(ifr3),
        .if_pc(pc3), .if_inst(in3), .id_valid(idv3), .id_ready(rdy3),
        .id_pc(idpc3), .id_inst(idin3), .count(cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (idv2 !== 1'b0)  begin n_fail++; $display("FAIL reset_id_valid got %0b want 0", idv2); end
        n_checks++; if (ifr2 !== 1'b1)  begin n_fail++; $display("FAIL reset_if_ready got %0b want 1", ifr2); end
        n_checks++; if (idpc2 !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h want 0", idpc2); end
        n_checks++; if (idin2 !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst got %h want 0", idin2); end
        n_checks++; if (cnt2 !== 2'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt2); end
        n_checks++; if (idv3 !== 1'b0 || ifr3 !== 1'b1 || cnt3 !== 2'd0)
            begin n_fail++; $display("FAIL reset_d3 valid=%0b ready=%0b count=%0d want 0/1/0", idv3, ifr3, cnt3); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_push();
        v2 = 1; pc2 = 32'h0; in2 = 32'h00500093; rdy2 = 0;
        step();
        v2 = 0;
        n_checks++; if (idv2 !== 1'b1) begin n_fail++; $display("FAIL push1_id_valid got %0b want 1", idv2); end
        n_checks++; if (idpc2 !== 32'h0) begin n_fail++; $display("FAIL push1_id_pc got %h want 0", idpc2); end
        n_checks++; if (idin2 !== 32'h00500093) begin n_fail++; $display("FAIL push1_id_inst got %h want 00500093", idin2); end
        n_checks++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL push1_count got %0d want 1", cnt2); end
        rdy2 = 1;
        step();
        rdy2 = 0;
        n_checks++; if (cnt2 !== 2'd0 || idv2 !== 1'b0) begin n_fail++; $display("FAIL pop1_empty count=%0d valid=%0b want 0/0", cnt2, idv2); end
    endtask

    task automatic test_backpressure();
        rdy2 = 0; v2 = 1;
        pc2 = 32'h4; in2 = 32'hA4; step();
        pc2 = 32'h8; in2 = 32'hA8; step();
        n_checks++; if (cnt2 !== 2'd2 || ifr2 !== 1'b0) begin n_fail++; $display("FAIL full_state count=%0d if_ready=%0b want 2/0", cnt2, ifr2); end
        pc2 = 32'hC; in2 = 32'hAC; step();
        n_checks++; if (cnt2 !== 2'd2 || idpc2 !== 32'h4) begin n_fail++; $display("FAIL held_full count=%0d id_pc=%h want 2/4", cnt2, idpc2); end
        // Full with pop and push together: push refused.
        rdy2 = 1; step();
        n_checks++; if (cnt2 !== 2'd1 || ifr2 !== 1'b1) begin n_fail++; $display("FAIL full_pushpop count=%0d if_ready=%0b want 1/1", cnt2, ifr2); end
        n_checks++; if (idpc2 !== 32'h8 || idin2 !== 32'hA8) begin n_fail++; $display("FAIL order_second pc=%h inst=%h want 8/a8", idpc2, idin2); end
        step();
        v2 = 0;
        n_checks++; if (cnt2 !== 2'd1 || idpc2 !== 32'hC || idin2 !== 32'hAC) begin n_fail++; $display("FAIL order_third count=%0d pc=%h inst=%h want 1/c/ac", cnt2, idpc2, idin2); end
        step();
        rdy2 = 0;
        n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL drain count=%0d want 0", cnt2); end
    endtask

    task automatic test_flush();
        rdy2 = 0; v2 = 1;
        pc2 = 32'h10; in2 = 32'hB0; step();
        pc2 = 32'h14; in2 = 32'hB4; step();
        flush2 = 1; pc2 = 32'h18; in2 = 32'hB8; step();
        flush2 = 0; v2 = 0;
        n_checks++; if (cnt2 !== 2'd0 || idv2 !== 1'b0 || idin2 !== 32'h0)
            begin n_fail++; $display("FAIL flush_full count=%0d valid=%0b inst=%h want 0/0/0", cnt2, idv2, idin2); end
        // Flush with room available must still drop the same-cycle push.
        v2 = 1; pc2 = 32'h20; in2 = 32'hC0; step();
        flush2 = 1; pc2 = 32'h24; in2 = 32'hC4; step();
        flush2 = 0; pc2 = 32'h28; in2 = 32'hC8; step();
        v2 = 0;
        n_checks++; if (cnt2 !== 2'd1 || idpc2 !== 32'h28 || idin2 !== 32'hC8)
            begin n_fail++; $display("FAIL flush_drop count=%0d pc=%h inst=%h want 1/28/c8", cnt2, idpc2, idin2); end
        rdy2 = 1; step(); rdy2 = 0;
    endtask

    task automatic test_async_reset();
        rdy2 = 0; v2 = 1;
        pc2 = 32'h30; in2 = 32'hD0; step();
        pc2 = 32'h34; in2 = 32'hD4; step();
        v2 = 0;
        n_checks++; if (cnt2 !== 2'd2) begin n_fail++; $display("FAIL pre_reset count=%0d want 2", cnt2); end
        #1 rst = 1;
        #1;
        n_checks++; if (cnt2 !== 2'd0 || idv2 !== 1'b0 || ifr2 !== 1'b1 || idpc2 !== 32'h0 || idin2 !== 32'h0)
            begin n_fail++; $display("FAIL async_reset count=%0d valid=%0b ready=%0b pc=%h inst=%h want 0/0/1/0/0", cnt2, idv2, ifr2, idpc2, idin2); end
        step();
        #2 rst = 0;
        step();
        v2 = 1; pc2 = 32'h40; in2 = 32'hE0; step();
        v2 = 0;
        n_checks++; if (cnt2 !== 2'd1 || idpc2 !== 32'h40 || idin2 !== 32'hE0)
            begin n_fail++; $display("FAIL post_reset_push count=%0d pc=%h inst=%h want 1/40/e0", cnt2, idpc2, idin2); end
        rdy2 = 1; step(); rdy2 = 0;
    endtask

    // DEPTH=3 against a queue model. mode 0: forced push+pop streaming,
    // mode 1: random valid/ready/flush.
    logic [63:0] model_q[$];

    task automatic run_stream(input int cycles, input int mode, input string name);
        logic        e_valid, e_ready, do_push, do_pop;
        logic [31:0] e_pc, e_inst;
        for (int i = 0; i < cycles; i++) begin
            e_valid = (model_q.size() != 0);
            e_ready = (model_q.size() != 3);
            e_pc    = e_valid ? model_q[0][63:32] : 32'h0;
            e_inst  = e_valid ? model_q[0][31:0]  : 32'h0;
            n_checks++; if (cnt3 !== 2'(model_q.size()))
                begin n_fail++; $display("FAIL %s_count cycle %0d got %0d want %0d", name, i, cnt3, model_q.size()); end
            n_checks++; if (idv3 !== e_valid || ifr3 !== e_ready)
                begin n_fail++; $display("FAIL %s_hs cycle %0d valid=%0b ready=%0b want %0b/%0b", name, i, idv3, ifr3, e_valid, e_ready); end
            n_checks++; if (idpc3 !== e_pc || idin3 !== e_inst)
                begin n_fail++; $display("FAIL %s_head cycle %0d pc=%h inst=%h want %h/%h", name, i, idpc3, idin3, e_pc, e_inst); end
            if (mode == 0) begin
                v3 = 1; rdy3 = 1; flush3 = 0;
                pc3 = 32'h1000 + 32'(i) * 4;
            end else begin
                v3 = ($urandom_range(0, 3) != 0);
                rdy3 = ($urandom_range(0, 2) != 0);
                flush3 = ($urandom_range(0, 15) == 0);
                pc3 = $urandom;
            end
            in3 = $urandom;
            do_push = v3 && e_ready && !flush3;
            do_pop  = e_valid && rdy3 && !flush3;
            if (flush3) model_q.delete();
            else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back({pc3, in3});
            end
            step();
        end
        v3 = 0; rdy3 = 0; flush3 = 0;
    endtask

    task automatic test_wrap_stream();
        model_q.delete();
        v3 = 1; pc3 = 32'h0FFC; in3 = 32'h13; rdy3 = 0; step();
        model_q.push_back({32'h0FFC, 32'h13});
        v3 = 0;
        run_stream(10, 0, "wrap");
        run_stream(2, 0, "wrap_tail");
    endtask

    task automatic test_random();
        run_stream(300, 1, "rand");
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wrap_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
